// File: rtl/audio_frontend.sv
// Audio front end: serial sample receiver, triangle test tone, link watchdog
// and registered output mux feeding the FM modulator.
module audio_frontend #(
    parameter int unsigned A           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 65536,
    parameter int unsigned TONE_DIV    = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclk_pin,
    input  logic                sdata_pin,
    input  logic                cs_n_pin,
    input  logic                tone_en,
    output logic signed [A-1:0] audio,
    output logic                sample_strobe,
    output logic                link_ok
);

    localparam int unsigned CNT_W = $clog2(A + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned PRE_W = $clog2(TONE_DIV);

    localparam logic signed [A-1:0] TRI_MAX = {1'b0, {(A-1){1'b1}}};
    localparam logic signed [A-1:0] TRI_MIN = {1'b1, {(A-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_END = 2'd2
    } rx_state_e;

    // Pin synchronisers and sclk history
    logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q, cs_n_sync_q;
    logic                   sclk_hist_q;
    logic                   sclk_s, sdata_s, cs_n_s, sclk_rise_c;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [A-1:0]           shift_q, shift_d;
    logic [A-1:0]           rx_word_c;
    logic                   rx_done_c;

    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   expire_c;

    logic [PRE_W-1:0]       pre_q, pre_d;
    logic signed [A-1:0]    tri_q, tri_d;
    logic                   up_q, up_d;
    logic                   tone_tick_c;

    logic signed [A-1:0]    audio_q, audio_d;
    logic                   strobe_q, strobe_d;
    logic                   link_ok_q, link_ok_d;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s     = sdata_sync_q[SYNC_STAGES-1];
    assign cs_n_s      = cs_n_sync_q[SYNC_STAGES-1];
    assign sclk_rise_c = sclk_s & ~sclk_hist_q;
    assign rx_word_c   = {shift_q[A-2:0], sdata_s};

    // Synchronise the three asynchronous pins into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            cs_n_sync_q  <= '0;
            sclk_hist_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_pin};
            cs_n_sync_q  <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n_pin};
            sclk_hist_q  <= sclk_s;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receiver next state: MSB-first shift, frame abort on early cs_n release
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_n_s) begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_n_s) begin
                    state_d = IDLE;
                end else if (sclk_rise_c) begin
                    shift_d   = rx_word_c;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(A - 1)) begin
                        rx_done_c = 1'b1;
                        state_d   = WAIT_END;
                    end
                end
            end
            WAIT_END: begin
                if (cs_n_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog, tone generator and output mux next-state
    always_comb begin
        wd_d      = wd_q;
        pre_d     = pre_q + PRE_W'(1);
        tri_d     = tri_q;
        up_d      = up_q;
        audio_d   = audio_q;
        strobe_d  = 1'b0;

        if (rx_done_c) begin
            wd_d = '0;
        end else if (wd_q != WD_W'(TIMEOUT)) begin
            wd_d = wd_q + WD_W'(1);
        end
        expire_c  = !rx_done_c && (wd_q == WD_W'(TIMEOUT - 1));
        link_ok_d = (wd_d < WD_W'(TIMEOUT));

        tone_tick_c = (pre_q == PRE_W'(TONE_DIV - 1));
        if (tone_tick_c) begin
            pre_d = '0;
            tri_d = up_q ? (tri_q + A'(1)) : (tri_q - A'(1));
            if (tri_d == TRI_MAX) begin
                up_d = 1'b0;
            end else if (tri_d == TRI_MIN) begin
                up_d = 1'b1;
            end
        end

        if (tone_en) begin
            if (tone_tick_c) begin
                audio_d  = tri_d;
                strobe_d = 1'b1;
            end
        end else if (rx_done_c) begin
            audio_d  = rx_word_c;
            strobe_d = 1'b1;
        end else if (expire_c) begin
            audio_d  = '0;
            strobe_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wd_q      <= WD_W'(TIMEOUT);
            pre_q     <= '0;
            tri_q     <= '0;
            up_q      <= 1'b1;
            audio_q   <= '0;
            strobe_q  <= 1'b0;
            link_ok_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wd_q      <= wd_d;
            pre_q     <= pre_d;
            tri_q     <= tri_d;
            up_q      <= up_d;
            audio_q   <= audio_d;
            strobe_q  <= strobe_d;
            link_ok_q <= link_ok_d;
        end
    end

    assign audio         = audio_q;
    assign sample_strobe = strobe_q;
    assign link_ok       = link_ok_q;

endmodule

// File: tb/tb_audio_frontend.sv
// Directed bench for audio_frontend: serial frames, abort, extra bits,
// watchdog expiry, triangle tone and reset in the middle of a word.
module tb_audio_frontend;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sclk_pin, sdata_pin, cs_n_pin, tone_en;
    logic signed [7:0] audio;
    logic              sample_strobe, link_ok;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;

    int e_val;
    bit e_up;
    bit have_prev;
    int prev_cyc;

    audio_frontend #(
        .A(8), .SYNC_STAGES(2), .TIMEOUT(64), .TONE_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .sdata_pin(sdata_pin),
        .cs_n_pin(cs_n_pin), .tone_en(tone_en), .audio(audio),
        .sample_strobe(sample_strobe), .link_ok(link_ok)
    );

    always #5 clk = ~clk;

    // Cycle counter and strobe counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sample_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    // Remember the cycle of the most recent strobe
    always @(negedge clk) begin
        if (sample_strobe) last_strobe_cyc <= cyc;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] aud();
        return {24'b0, audio};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of word out MSB-first, 8 clk per sclk period
    task automatic send_bits(input logic [15:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdata_pin = word[i];
            wait_clk(4);
            sclk_pin = 1'b1;
            wait_clk(4);
            sclk_pin = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] word, input int nbits);
        cs_n_pin = 1'b0;
        wait_clk(4);
        send_bits(word, nbits);
        wait_clk(4);
        cs_n_pin = 1'b1;
        wait_clk(4);
    endtask

    // Follow n tone strobes against the triangle model
    task automatic check_tone(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            logic [7:0] ev8;
            do begin
                @(negedge clk);
                w++;
            end while (!sample_strobe && w < 8);
            if (!sample_strobe) begin
                check("tone_strobe_timeout", 32'd0, 32'd1);
                return;
            end
            if (have_prev) check("tone_interval", 32'(cyc - prev_cyc), 32'd2);
            prev_cyc  = cyc;
            have_prev = 1'b1;
            e_val = e_up ? e_val + 1 : e_val - 1;
            if (e_val == 127) e_up = 1'b0;
            else if (e_val == -127) e_up = 1'b1;
            ev8 = 8'(e_val);
            check("tone_value", aud(), {24'b0, ev8});
        end
    endtask

    initial begin
        int s0;
        int k;

        rst_n = 1'b0; sclk_pin = 1'b0; sdata_pin = 1'b0; cs_n_pin = 1'b1; tone_en = 1'b0;
        wait_clk(3);
        check("rst_audio", aud(), 32'h0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        check("rst_link_ok", 32'(link_ok), 32'd0);
        rst_n = 1'b1;
        s0 = strobe_cnt;
        wait_clk(10);
        check("post_rst_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("post_rst_link_ok", 32'(link_ok), 32'd0);

        // Plain word
        s0 = strobe_cnt;
        send_frame(16'h5A, 8);
        check("w5a_audio", aud(), 32'h5A);
        check("w5a_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("w5a_link_ok", 32'(link_ok), 32'd1);
        wait_clk(80);
        check("w5a_expired_audio", aud(), 32'h0);
        check("w5a_expired_link", 32'(link_ok), 32'd0);

        // Aborted frame then 0x80
        s0 = strobe_cnt;
        send_frame(16'h16, 5);
        check("abort_strobes", 32'(strobe_cnt - s0), 32'd0);
        check("abort_audio", aud(), 32'h0);
        s0 = strobe_cnt;
        send_frame(16'h80, 8);
        check("w80_audio", aud(), 32'h80);
        check("w80_strobes", 32'(strobe_cnt - s0), 32'd1);
        wait_clk(80);

        // Eleven bits: 0x3C then three ones
        s0 = strobe_cnt;
        send_frame(16'h1E7, 11);
        check("extra_audio", aud(), 32'h3C);
        check("extra_strobes", 32'(strobe_cnt - s0), 32'd1);
        wait_clk(80);

        // Watchdog timing after word 0x10
        send_frame(16'h10, 8);
        k = last_strobe_cyc;
        s0 = strobe_cnt;
        check("w10_audio", aud(), 32'h10);
        while (cyc < k + 63) @(negedge clk);
        check("wd_pre_audio", aud(), 32'h10);
        check("wd_pre_link", 32'(link_ok), 32'd1);
        check("wd_pre_strobe", 32'(sample_strobe), 32'd0);
        @(negedge clk);
        check("wd_exp_audio", aud(), 32'h0);
        check("wd_exp_strobe", 32'(sample_strobe), 32'd1);
        check("wd_exp_link", 32'(link_ok), 32'd0);
        wait_clk(10);
        check("wd_exp_strobes", 32'(strobe_cnt - s0), 32'd1);
        send_frame(16'h33, 8);
        check("w33_audio", aud(), 32'h33);
        check("w33_link_ok", 32'(link_ok), 32'd1);

        // Tone mode from a fresh reset; a serial word arrives meanwhile
        rst_n = 1'b0;
        tone_en = 1'b1;
        wait_clk(3);
        e_val = 0; e_up = 1'b1; have_prev = 1'b0; prev_cyc = 0;
        rst_n = 1'b1;
        fork
            send_frame(16'hA5, 8);
            check_tone(60);
        join
        check("tone_link_ok", 32'(link_ok), 32'd1);
        check_tone(600);
        tone_en = 1'b0;
        wait_clk(80);

        // Reset in the middle of a word
        cs_n_pin = 1'b0;
        wait_clk(4);
        send_bits(16'h7, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_audio", aud(), 32'h0);
        check("midrst_strobe", 32'(sample_strobe), 32'd0);
        check("midrst_link", 32'(link_ok), 32'd0);
        wait_clk(5);
        cs_n_pin = 1'b1;
        rst_n = 1'b1;
        s0 = strobe_cnt;
        wait_clk(5);
        send_frame(16'h7F, 8);
        check("w7f_audio", aud(), 32'h7F);
        check("w7f_strobes", 32'(strobe_cnt - s0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
